mcu_alu_seq: RTL and testbench
==============================

Name: mcu_alu_seq

Overview:
Parametrised, registered ALU for the 8051 core. It supersedes the combinational single-cycle ALU.
- Keeps the same 5-bit opcode map.
- Adds a start/busy/done handshake and iterative DW-cycle MUL/DIV, and returns the high half of MUL and the remainder of DIV.
- Adds full PSW flag generation (CY, AC, OV, P) and a true DA.
- Sits between the decode/execute FSM and the ACC/B/PSW register file.

Parameters:
DW, 8, operand/result width; must be a multiple of 4, minimum 8
CNT_W, $clog2(DW+1), width of the iteration counter

Ports:
clk  input  1  core clock
rst_n  input  1  reset, synchronous, active-low
start  input  1  operation request; sampled only when busy=0
op  input  5  opcode: 0 ADD, 1 ADDC, 2 INC, 3 DEC, 4 SUBB, 5 MUL, 6 DIV, 7 DA, 8 ANL, 9 ORL, A XRL, B SETB, C CLR, D CPL, E RL, F RLC, 10 RR, 11 RRC, 12 SWAP
a_data  input  DW  operand A (ACC)
b_data  input  DW  operand B
c_in  input  1  PSW.CY in
ac_in  input  1  PSW.AC in (used by DA)
busy  output  1  iterative op in progress
done  output  1  one-cycle pulse; result/flag outputs valid from this cycle
ans  output  DW  result (MUL low half, DIV quotient)
ans_hi  output  DW  MUL high half / DIV remainder; 0 for other ops
cy_out  output  1  carry/borrow
ac_out  output  1  auxiliary carry (nibble 0 carry/borrow)
ov_out  output  1  overflow
p_out  output  1  even parity of ans (XOR-reduce)
flag_upd  output  3  {cy,ac,ov} write-enable mask for PSW, valid with done
illegal_op  output  1  pulses with done for opcodes 0x13..0x1F

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - State returns to IDLE.
  - busy, done, illegal_op, flag_upd, ans, ans_hi, cy_out, ac_out, ov_out, p_out are all 0.
  - Any iteration in progress is aborted and no done is issued for it.
- FSM states: IDLE, ITER, FIN.
- Operand capture: start with busy=0 latches op, a_data, b_data, c_in and ac_in. Later input changes have no effect.
- Single-cycle ops (everything except MUL, DIV with b≠0):
  - Result is registered at the capture edge; done=1 in the following cycle; state stays IDLE.
  - Back-to-back starts give one result per cycle.
- MUL and DIV with b≠0:
  - IDLE→ITER, busy=1 from the next cycle.
  - DW iterations: shift-add multiply, restoring divide.
  - ITER→FIN after DW cycles; FIN→IDLE after 1 cycle.
  - done pulses in FIN, DW+1 cycles after capture; busy is low in FIN.
- start while busy=1 is ignored; no queueing.
- Outputs hold their last value until the next done.
- Arithmetic rules:
  - ADD/ADDC: (DW+1)-bit sum. CY = bit DW. AC = carry out of bit 3. OV = signed overflow. flag_upd=111.
  - SUBB: a−b−c_in. CY = borrow out of the MSB. AC = borrow from bit 3. OV = signed overflow. flag_upd=111.
  - INC/DEC: wrap modulo 2^DW, flag_upd=000.
  - MUL: {ans_hi,ans}=a*b. CY=0. OV=(ans_hi≠0). flag_upd=101.
  - DIV: ans=a/b, ans_hi=a%b, CY=0, OV=0, flag_upd=101.
  - DIV with b=0: single-cycle. ans=all ones, ans_hi=a, OV=1, CY=0.
  - DA: per 8051, generalised per nibble. For each nibble from the LSB up: if nibble>9, or (lowest nibble and ac_in), or (top nibble and c_in) → add 6 to it, with carry ripple. CY = c_in OR carry out of the top. flag_upd=100.
  - ANL/ORL/XRL/CPL/RL/RR/SWAP: flag_upd=000. SWAP exchanges the upper and lower DW/2 halves.
  - RLC/RRC: rotate through c_in; cy_out = bit shifted out; flag_upd=100.
  - SETB: ans=1, cy_out=1. CLR: ans=0, cy_out=0. Both flag_upd=100.
- p_out always reflects the registered ans.
- Illegal opcode: ans=0, ans_hi=0, flag_upd=000, illegal_op=1, done=1 (single cycle).

Decomposition:
- Package mcu_alu_pkg holds:
  - the opcode localparams (OP_ADD..OP_SWAP, OP_LAST=5'h12);
  - the FSM state encoding;
  - flag index constants FLG_CY=2, FLG_AC=1, FLG_OV=0.
- Sub-module mcu_alu_muldiv (parametrised DW): iterative shift-add multiplier / restoring divider with start/last-cycle strobe. The top module owns the FSM, the counter and the single-cycle datapath.

Test Plan:
- ADD a=0x7F b=0x01 → next cycle done=1, ans=0x80, CY=0, AC=1, OV=1, P=1, flag_upd=111.
- SUBB a=0x00 b=0x01 c_in=0 → ans=0xFF, CY=1, AC=1, OV=0, P=0.
- MUL a=0x80 b=0x02 → busy high for 8 cycles, done 9 cycles after capture, ans=0x00, ans_hi=0x01, OV=1, CY=0. A start issued mid-run is ignored.
- DIV a=0xFB b=0x12 → done at cycle 9, ans=0x0D, ans_hi=0x11. DIV a=0x55 b=0x00 → done next cycle, ans=0xFF, ans_hi=0x55, OV=1.
- DA a=0x9B ac_in=0 c_in=0 → ans=0x01, CY=1, flag_upd=100. RLC a=0x81 c_in=0 → ans=0x02, CY=1.
- rst_n low during MUL iteration 3 → next cycle busy=0, done=0, all outputs 0, no late done; a following ADD 0x01+0x01 returns 0x02 one cycle after capture. Also run the DW=16 variant: ADD 0xFFFF+0x0001 → ans=0x0000, CY=1.

Source files
------------

// File: rtl/mcu_alu_pkg.sv
// Shared opcode map, FSM encoding and PSW flag indices for the sequential 8051 ALU.
package mcu_alu_pkg;

   localparam int unsigned OP_W  = 5;
   localparam int unsigned FLG_W = 3;

   localparam logic [OP_W-1:0] OP_ADD  = 5'h00;
   localparam logic [OP_W-1:0] OP_ADDC = 5'h01;
   localparam logic [OP_W-1:0] OP_INC  = 5'h02;
   localparam logic [OP_W-1:0] OP_DEC  = 5'h03;
   localparam logic [OP_W-1:0] OP_SUBB = 5'h04;
   localparam logic [OP_W-1:0] OP_MUL  = 5'h05;
   localparam logic [OP_W-1:0] OP_DIV  = 5'h06;
   localparam logic [OP_W-1:0] OP_DA   = 5'h07;
   localparam logic [OP_W-1:0] OP_ANL  = 5'h08;
   localparam logic [OP_W-1:0] OP_ORL  = 5'h09;
   localparam logic [OP_W-1:0] OP_XRL  = 5'h0A;
   localparam logic [OP_W-1:0] OP_SETB = 5'h0B;
   localparam logic [OP_W-1:0] OP_CLR  = 5'h0C;
   localparam logic [OP_W-1:0] OP_CPL  = 5'h0D;
   localparam logic [OP_W-1:0] OP_RL   = 5'h0E;
   localparam logic [OP_W-1:0] OP_RLC  = 5'h0F;
   localparam logic [OP_W-1:0] OP_RR   = 5'h10;
   localparam logic [OP_W-1:0] OP_RRC  = 5'h11;
   localparam logic [OP_W-1:0] OP_SWAP = 5'h12;
   localparam logic [OP_W-1:0] OP_LAST = 5'h12;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ITER = 2'd1,
      ST_FIN  = 2'd2
   } state_e;

   // Bit positions inside the {cy,ac,ov} flag_upd mask
   localparam int unsigned FLG_CY = 2;
   localparam int unsigned FLG_AC = 1;
   localparam int unsigned FLG_OV = 0;

endpackage

// File: rtl/mcu_alu_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one bit per step.
// lo_c/hi_c present the value the current step produces, so the caller can capture the final step directly.
module mcu_alu_muldiv #(
   parameter int unsigned DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic          step,
   input  logic          is_div,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic [DW-1:0] lo_c,
   output logic [DW-1:0] hi_c
);

   logic [DW-1:0] hi_q, hi_d;
   logic [DW-1:0] lo_q, lo_d;
   logic [DW-1:0] b_q, b_d;
   logic [DW:0]   madd;
   logic [DW:0]   shl;
   logic          ge;

   // hi holds the partial product / running remainder, lo the multiplier / quotient
   always_comb begin
      madd = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      shl  = {hi_q, lo_q[DW-1]};
      ge   = (shl >= {1'b0, b_q});
      if (is_div) begin
         hi_c = ge ? (shl[DW-1:0] - b_q) : shl[DW-1:0];
         lo_c = {lo_q[DW-2:0], ge};
      end else begin
         hi_c = madd[DW:1];
         lo_c = {madd[0], lo_q[DW-1:1]};
      end
      hi_d = hi_q;
      lo_d = lo_q;
      b_d  = b_q;
      if (load) begin
         hi_d = '0;
         lo_d = a;
         b_d  = b;
      end else if (step) begin
         hi_d = hi_c;
         lo_d = lo_c;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hi_q <= '0;
         lo_q <= '0;
         b_q  <= '0;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
         b_q  <= b_d;
      end
   end

endmodule

// File: rtl/mcu_alu_seq.sv
// Registered 8051 ALU with start/busy/done handshake, iterative MUL/DIV and full PSW flag generation.
module mcu_alu_seq
   import mcu_alu_pkg::*;
#(
   parameter int unsigned DW    = 8,
   parameter int unsigned CNT_W = $clog2(DW + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [OP_W-1:0]  op,
   input  logic [DW-1:0]    a_data,
   input  logic [DW-1:0]    b_data,
   input  logic             c_in,
   input  logic             ac_in,
   output logic             busy,
   output logic             done,
   output logic [DW-1:0]    ans,
   output logic [DW-1:0]    ans_hi,
   output logic             cy_out,
   output logic             ac_out,
   output logic             ov_out,
   output logic             p_out,
   output logic [FLG_W-1:0] flag_upd,
   output logic             illegal_op
);

   localparam int unsigned XW  = DW + 1;
   localparam int unsigned NIB = DW / 4;
   localparam int unsigned HW  = DW / 2;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              ill_q, ill_d;
   logic              div_q, div_d;
   logic [DW-1:0]     ans_q, ans_d;
   logic [DW-1:0]     hi_q, hi_d;
   logic              cy_q, cy_d;
   logic              ac_q, ac_d;
   logic              ov_q, ov_d;
   logic              p_q, p_d;
   logic [FLG_W-1:0]  upd_q, upd_d;

   logic [XW-1:0]     add_s, sub_s, da_v;
   logic [DW-1:0]     sc_ans, sc_hi;
   logic              sc_cy, sc_ac, sc_ov, sc_ill;
   logic [FLG_W-1:0]  sc_upd;
   logic              is_iter_c;

   logic              md_load, md_step;
   logic [DW-1:0]     md_lo_c, md_hi_c;

   mcu_alu_muldiv #(.DW(DW)) u_muldiv (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (md_load),
      .step   (md_step),
      .is_div (div_q),
      .a      (a_data),
      .b      (b_data),
      .lo_c   (md_lo_c),
      .hi_c   (md_hi_c)
   );

   // Single-cycle datapath straight from the inputs; its result is registered at the capture edge
   always_comb begin
      add_s = {1'b0, a_data} + {1'b0, b_data} + XW'((op == OP_ADDC) & c_in);
      sub_s = {1'b0, a_data} - {1'b0, b_data} - XW'(c_in);
      da_v  = {1'b0, a_data};
      for (int i = 0; i < int'(NIB); i++) begin
         if ((da_v[4*i +: 4] > 4'd9) || ((i == 0) && ac_in) || ((i == int'(NIB) - 1) && c_in))
            da_v = da_v + (XW'(6) << (4 * i));
      end

      sc_ans = '0;
      sc_hi  = '0;
      sc_cy  = 1'b0;
      sc_ac  = 1'b0;
      sc_ov  = 1'b0;
      sc_upd = '0;
      sc_ill = 1'b0;
      // Nibble carry/borrow and MSB carry-in recovered as a^b^result of the bit above
      case (op)
         OP_ADD, OP_ADDC: begin
            sc_ans = add_s[DW-1:0];
            sc_cy  = add_s[DW];
            sc_ac  = a_data[4] ^ b_data[4] ^ add_s[4];
            sc_ov  = add_s[DW] ^ a_data[DW-1] ^ b_data[DW-1] ^ add_s[DW-1];
            sc_upd = 3'b111;
         end
         OP_SUBB: begin
            sc_ans = sub_s[DW-1:0];
            sc_cy  = sub_s[DW];
            sc_ac  = a_data[4] ^ b_data[4] ^ sub_s[4];
            sc_ov  = sub_s[DW] ^ a_data[DW-1] ^ b_data[DW-1] ^ sub_s[DW-1];
            sc_upd = 3'b111;
         end
         OP_INC:  sc_ans = a_data + DW'(1);
         OP_DEC:  sc_ans = a_data - DW'(1);
         OP_MUL:  sc_ans = '0;
         OP_DIV: begin
            sc_ans = '1;
            sc_hi  = a_data;
            sc_ov  = 1'b1;
            sc_upd = 3'b101;
         end
         OP_DA: begin
            sc_ans = da_v[DW-1:0];
            sc_cy  = c_in | da_v[DW];
            sc_upd = 3'b100;
         end
         OP_ANL:  sc_ans = a_data & b_data;
         OP_ORL:  sc_ans = a_data | b_data;
         OP_XRL:  sc_ans = a_data ^ b_data;
         OP_SETB: begin
            sc_ans = DW'(1);
            sc_cy  = 1'b1;
            sc_upd = 3'b100;
         end
         OP_CLR:  sc_upd = 3'b100;
         OP_CPL:  sc_ans = ~a_data;
         OP_RL:   sc_ans = {a_data[DW-2:0], a_data[DW-1]};
         OP_RLC: begin
            sc_ans = {a_data[DW-2:0], c_in};
            sc_cy  = a_data[DW-1];
            sc_upd = 3'b100;
         end
         OP_RR:   sc_ans = {a_data[0], a_data[DW-1:1]};
         OP_RRC: begin
            sc_ans = {c_in, a_data[DW-1:1]};
            sc_cy  = a_data[0];
            sc_upd = 3'b100;
         end
         OP_SWAP: sc_ans = {a_data[HW-1:0], a_data[DW-1:HW]};
         default: sc_ill = 1'b1;
      endcase
   end

   assign is_iter_c = (op == OP_MUL) || ((op == OP_DIV) && (b_data != '0));

   // Next-state and output logic; results hold until the next done
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      ill_d   = 1'b0;
      div_d   = div_q;
      ans_d   = ans_q;
      hi_d    = hi_q;
      cy_d    = cy_q;
      ac_d    = ac_q;
      ov_d    = ov_q;
      upd_d   = upd_q;
      md_load = 1'b0;
      md_step = 1'b0;
      case (state_q)
         ST_ITER: begin
            md_step = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DW - 1)) begin
               state_d = ST_FIN;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               ans_d   = md_lo_c;
               hi_d    = md_hi_c;
               cy_d    = 1'b0;
               ac_d    = 1'b0;
               ov_d    = !div_q && (md_hi_c != '0);
               upd_d   = 3'b101;
            end
         end
         default: begin
            // IDLE and FIN both have busy low, so either may accept a new operation
            state_d = ST_IDLE;
            if (start) begin
               if (is_iter_c) begin
                  state_d = ST_ITER;
                  busy_d  = 1'b1;
                  cnt_d   = '0;
                  md_load = 1'b1;
                  div_d   = (op == OP_DIV);
               end else begin
                  done_d = 1'b1;
                  ans_d  = sc_ans;
                  hi_d   = sc_hi;
                  cy_d   = sc_cy;
                  ac_d   = sc_ac;
                  ov_d   = sc_ov;
                  upd_d  = sc_upd;
                  ill_d  = sc_ill;
               end
            end
         end
      endcase
      p_d = ^ans_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ill_q   <= 1'b0;
         div_q   <= 1'b0;
         ans_q   <= '0;
         hi_q    <= '0;
         cy_q    <= 1'b0;
         ac_q    <= 1'b0;
         ov_q    <= 1'b0;
         p_q     <= 1'b0;
         upd_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ill_q   <= ill_d;
         div_q   <= div_d;
         ans_q   <= ans_d;
         hi_q    <= hi_d;
         cy_q    <= cy_d;
         ac_q    <= ac_d;
         ov_q    <= ov_d;
         p_q     <= p_d;
         upd_q   <= upd_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign ans        = ans_q;
   assign ans_hi     = hi_q;
   assign cy_out     = cy_q;
   assign ac_out     = ac_q;
   assign ov_out     = ov_q;
   assign p_out      = p_q;
   assign flag_upd   = upd_q;
   assign illegal_op = ill_q;

endmodule

// File: tb/tb_mcu_alu_seq.sv
// Vector table plus handshake/abort sequences for mcu_alu_seq (DW=8), with a small DW=16 check.
module tb_mcu_alu_seq;
   import mcu_alu_pkg::*;

   typedef struct {
      logic [4:0] op;
      logic [7:0] a, b;
      logic       cin, acin;
      logic [7:0] ans, hi;
      logic       cy, ac, ov;
      logic [2:0] upd;
      logic       ill;
      int         lat;
   } vec_t;

   typedef struct {
      logic [7:0] ans, hi;
      logic       cy, ac, ov;
      logic [2:0] upd;
      logic       ill;
      int         due;
   } exp_t;

   logic       clk, rst_n;
   logic       start, c_in, ac_in;
   logic [4:0] op;
   logic [7:0] a_data, b_data;
   logic       busy, done, cy_out, ac_out, ov_out, p_out, illegal_op;
   logic [7:0] ans, ans_hi;
   logic [2:0] flag_upd;

   logic        s_start, s_cin, s_acin;
   logic [4:0]  s_op;
   logic [15:0] s_a, s_b;
   logic        s_busy, s_done, s_cy, s_ac, s_ov, s_p, s_ill;
   logic [15:0] s_ans, s_hi;
   logic [2:0]  s_upd;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   vec_t vecs[$];
   exp_t sb[$];
   exp_t mon_e;

   mcu_alu_seq #(.DW(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a_data(a_data), .b_data(b_data),
      .c_in(c_in), .ac_in(ac_in), .busy(busy), .done(done), .ans(ans), .ans_hi(ans_hi),
      .cy_out(cy_out), .ac_out(ac_out), .ov_out(ov_out), .p_out(p_out),
      .flag_upd(flag_upd), .illegal_op(illegal_op)
   );

   mcu_alu_seq #(.DW(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(s_start), .op(s_op), .a_data(s_a), .b_data(s_b),
      .c_in(s_cin), .ac_in(s_acin), .busy(s_busy), .done(s_done), .ans(s_ans), .ans_hi(s_hi),
      .cy_out(s_cy), .ac_out(s_ac), .ov_out(s_ov), .p_out(s_p),
      .flag_upd(s_upd), .illegal_op(s_ill)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic add_vec(input logic [4:0] o, input logic [7:0] a, input logic [7:0] b,
                          input logic ci, input logic aci, input logic [7:0] r, input logic [7:0] h,
                          input logic cy, input logic ac, input logic ov, input logic [2:0] u,
                          input logic il, input int lat);
      vec_t v;
      v.op = o; v.a = a; v.b = b; v.cin = ci; v.acin = aci;
      v.ans = r; v.hi = h; v.cy = cy; v.ac = ac; v.ov = ov; v.upd = u; v.ill = il; v.lat = lat;
      vecs.push_back(v);
   endtask

   // Drive one start at a falling edge and record what the DUT owes
   task automatic issue(input vec_t v);
      exp_t e;
      start = 1'b1; op = v.op; a_data = v.a; b_data = v.b; c_in = v.cin; ac_in = v.acin;
      e.ans = v.ans; e.hi = v.hi; e.cy = v.cy; e.ac = v.ac; e.ov = v.ov;
      e.upd = v.upd; e.ill = v.ill; e.due = cyc + v.lat;
      sb.push_back(e);
      @(negedge clk);
   endtask

   task automatic wait_idle();
      int n = 0;
      start = 1'b0;
      while (sb.size() != 0 && n < 40) begin
         a_data = 8'($urandom); b_data = 8'($urandom); op = 5'($urandom);
         c_in = 1'($urandom); ac_in = 1'($urandom);
         @(negedge clk);
         n++;
      end
      chk("drain", 32'(sb.size()), 32'd0);
   endtask

   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'(done), 32'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("latency", 32'(cyc), 32'(mon_e.due));
            chk("ans", 32'(ans), 32'(mon_e.ans));
            chk("ans_hi", 32'(ans_hi), 32'(mon_e.hi));
            chk("flag_upd", 32'(flag_upd), 32'(mon_e.upd));
            chk("illegal_op", 32'(illegal_op), 32'(mon_e.ill));
            chk("parity", 32'(p_out), 32'(^mon_e.ans));
            if (mon_e.upd[FLG_CY]) chk("cy", 32'(cy_out), 32'(mon_e.cy));
            if (mon_e.upd[FLG_AC]) chk("ac", 32'(ac_out), 32'(mon_e.ac));
            if (mon_e.upd[FLG_OV]) chk("ov", 32'(ov_out), 32'(mon_e.ov));
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      int   bc;
      int   n;

      //       op       a      b      ci aci  ans    hi     cy ac ov upd     il lat
      add_vec(OP_ADD,  8'h7F, 8'h01, 0, 0, 8'h80, 8'h00, 0, 1, 1, 3'b111, 0, 1);
      add_vec(OP_ADDC, 8'hFF, 8'h00, 1, 0, 8'h00, 8'h00, 1, 1, 0, 3'b111, 0, 1);
      add_vec(OP_SUBB, 8'h00, 8'h01, 0, 0, 8'hFF, 8'h00, 1, 1, 0, 3'b111, 0, 1);
      add_vec(OP_SUBB, 8'h80, 8'h01, 0, 0, 8'h7F, 8'h00, 0, 1, 1, 3'b111, 0, 1);
      add_vec(OP_SUBB, 8'h50, 8'h20, 1, 0, 8'h2F, 8'h00, 0, 1, 0, 3'b111, 0, 1);
      add_vec(OP_INC,  8'hFF, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 3'b000, 0, 1);
      add_vec(OP_DEC,  8'h00, 8'h00, 0, 0, 8'hFF, 8'h00, 0, 0, 0, 3'b000, 0, 1);
      add_vec(OP_MUL,  8'h80, 8'h02, 0, 0, 8'h00, 8'h01, 0, 0, 1, 3'b101, 0, 9);
      add_vec(OP_MUL,  8'hFF, 8'hFF, 1, 0, 8'h01, 8'hFE, 0, 0, 1, 3'b101, 0, 9);
      add_vec(OP_MUL,  8'h0F, 8'h0F, 0, 0, 8'hE1, 8'h00, 0, 0, 0, 3'b101, 0, 9);
      add_vec(OP_DIV,  8'hFB, 8'h12, 0, 0, 8'h0D, 8'h11, 0, 0, 0, 3'b101, 0, 9);
      add_vec(OP_DIV,  8'hFF, 8'h01, 1, 0, 8'hFF, 8'h00, 0, 0, 0, 3'b101, 0, 9);
      add_vec(OP_DA,   8'h9B, 8'h00, 0, 0, 8'h01, 8'h00, 1, 0, 0, 3'b100, 0, 1);
      add_vec(OP_DA,   8'h25, 8'h00, 0, 1, 8'h2B, 8'h00, 0, 0, 0, 3'b100, 0, 1);
      add_vec(OP_DA,   8'h12, 8'h00, 1, 0, 8'h72, 8'h00, 1, 0, 0, 3'b100, 0, 1);
      add_vec(OP_ANL,  8'hF0, 8'h3C, 0, 0, 8'h30, 8'h00, 0, 0, 0, 3'b000, 0, 1);
      add_vec(OP_ORL,  8'hF0, 8'h3C, 0, 0, 8'hFC, 8'h00, 0, 0, 0, 3'b000, 0, 1);
      add_vec(OP_XRL,  8'hF0, 8'h3C, 0, 0, 8'hCC, 8'h00, 0, 0, 0, 3'b000, 0, 1);
      add_vec(OP_SETB, 8'hF0, 8'h00, 0, 0, 8'h01, 8'h00, 1, 0, 0, 3'b100, 0, 1);
      add_vec(OP_CLR,  8'hF0, 8'h00, 1, 0, 8'h00, 8'h00, 0, 0, 0, 3'b100, 0, 1);
      add_vec(OP_CPL,  8'h5A, 8'h00, 0, 0, 8'hA5, 8'h00, 0, 0, 0, 3'b000, 0, 1);
      add_vec(OP_RL,   8'h81, 8'h00, 0, 0, 8'h03, 8'h00, 0, 0, 0, 3'b000, 0, 1);
      add_vec(OP_RLC,  8'h81, 8'h00, 0, 0, 8'h02, 8'h00, 1, 0, 0, 3'b100, 0, 1);
      add_vec(OP_RR,   8'h81, 8'h00, 0, 0, 8'hC0, 8'h00, 0, 0, 0, 3'b000, 0, 1);
      add_vec(OP_RRC,  8'h02, 8'h00, 1, 0, 8'h81, 8'h00, 0, 0, 0, 3'b100, 0, 1);
      add_vec(OP_RRC,  8'h81, 8'h00, 0, 0, 8'h40, 8'h00, 1, 0, 0, 3'b100, 0, 1);
      add_vec(OP_SWAP, 8'hA5, 8'h00, 0, 0, 8'h5A, 8'h00, 0, 0, 0, 3'b000, 0, 1);
      add_vec(5'h13,   8'h12, 8'h34, 0, 0, 8'h00, 8'h00, 0, 0, 0, 3'b000, 1, 1);
      add_vec(5'h1F,   8'hFF, 8'hFF, 1, 1, 8'h00, 8'h00, 0, 0, 0, 3'b000, 1, 1);
      add_vec(OP_DIV,  8'h55, 8'h00, 0, 0, 8'hFF, 8'h55, 0, 0, 1, 3'b101, 0, 1);

      rst_n = 1'b0; start = 1'b0; op = '0; a_data = '0; b_data = '0; c_in = 1'b0; ac_in = 1'b0;
      s_start = 1'b0; s_op = '0; s_a = '0; s_b = '0; s_cin = 1'b0; s_acin = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ans", 32'(ans), 32'd0);
      chk("rst_upd", 32'(flag_upd), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Table: single-cycle ops back to back, iterative ops drained before moving on
      foreach (vecs[i]) begin
         v = vecs[i];
         issue(v);
         if (v.lat > 1) wait_idle();
      end
      wait_idle();

      // Abort a MUL during its third iteration
      start = 1'b1; op = OP_MUL; a_data = 8'h80; b_data = 8'h02; c_in = 1'b0; ac_in = 1'b0;
      @(negedge clk);
      start = 1'b0;
      chk("abort_busy_before", 32'(busy), 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_ans", 32'(ans), 32'd0);
      chk("abort_ans_hi", 32'(ans_hi), 32'd0);
      chk("abort_flags", 32'({cy_out, ac_out, ov_out, p_out}), 32'd0);
      chk("abort_upd", 32'(flag_upd), 32'd0);
      chk("abort_ill", 32'(illegal_op), 32'd0);
      repeat (12) @(negedge clk);
      chk("abort_idle", 32'(busy), 32'd0);
      v.op = OP_ADD; v.a = 8'h01; v.b = 8'h01; v.cin = 1'b0; v.acin = 1'b0;
      v.ans = 8'h02; v.hi = 8'h00; v.cy = 1'b0; v.ac = 1'b0; v.ov = 1'b0;
      v.upd = 3'b111; v.ill = 1'b0; v.lat = 1;
      issue(v);
      wait_idle();

      // MUL with a start mid-run that must be ignored; busy spans exactly DW cycles
      v.op = OP_MUL; v.a = 8'h80; v.b = 8'h02; v.cin = 1'b0; v.acin = 1'b0;
      v.ans = 8'h00; v.hi = 8'h01; v.cy = 1'b0; v.ac = 1'b0; v.ov = 1'b1;
      v.upd = 3'b101; v.ill = 1'b0; v.lat = 9;
      issue(v);
      bc = 0;
      for (int k = 0; k < 12; k++) begin
         start = (k == 2);
         if (k == 2) begin
            op = OP_ADD; a_data = 8'h11; b_data = 8'h22;
         end
         if (busy) bc++;
         @(negedge clk);
      end
      start = 1'b0;
      chk("busy_cycles", 32'(bc), 32'd8);
      wait_idle();

      // DW=16 instance: carry out of the full word, a 16-step MUL and a four-nibble DA
      s_start = 1'b1; s_op = OP_ADD; s_a = 16'hFFFF; s_b = 16'h0001;
      @(negedge clk);
      s_start = 1'b0;
      chk("w16_add_done", 32'(s_done), 32'd1);
      chk("w16_add_ans", 32'(s_ans), 32'h0000);
      chk("w16_add_cy", 32'(s_cy), 32'd1);
      chk("w16_add_ac", 32'(s_ac), 32'd1);
      chk("w16_add_ov", 32'(s_ov), 32'd0);
      s_start = 1'b1; s_op = OP_MUL; s_a = 16'h1234; s_b = 16'h0100;
      @(negedge clk);
      s_start = 1'b0; s_a = 16'hBEEF; s_b = 16'h0003;
      n = 1;
      while (!s_done && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("w16_mul_lat", 32'(n), 32'd17);
      chk("w16_mul_ans", 32'(s_ans), 32'h3400);
      chk("w16_mul_hi", 32'(s_hi), 32'h0012);
      chk("w16_mul_ov", 32'(s_ov), 32'd1);
      s_start = 1'b1; s_op = OP_DA; s_a = 16'h0A9B; s_cin = 1'b0; s_acin = 1'b0;
      @(negedge clk);
      s_start = 1'b0;
      chk("w16_da_ans", 32'(s_ans), 32'h1101);
      chk("w16_da_cy", 32'(s_cy), 32'd0);
      chk("w16_da_upd", 32'(s_upd), 32'b100);

      repeat (3) @(negedge clk);
      chk("final_queue", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
